alu_muldiv_lane_sequencer: RTL and testbench

- Request-side stage directly upstream of the ALU mul/div unit.
- Accepts one full-warp mul/div request (NUM_THREADS lanes of rs1/rs2 plus a tag) and splits it into NUM_THREADS/NUM_LANES lane batches.
- Emits the batches one per handshake, stamping each with pid/sop/eop so the mul/div unit and its commit path can rebuild the warp result.
- Optionally skips batches whose thread mask is all zero, cutting occupancy for divergent warps.

---
 rtl/alu_muldiv_lane_sequencer_pkg.sv | 19 +
 rtl/alu_muldiv_lane_sequencer_if.sv | 41 ++++
 rtl/alu_muldiv_lane_sequencer_lane_batch_finder.sv | 34 +++
 rtl/alu_muldiv_lane_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_muldiv_lane_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_lane_sequencer_pkg.sv
// Shared types and sizing helpers for the mul/div lane sequencer
// and the matching response-side gather stage.
package alu_muldiv_lane_sequencer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic int num_batches(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

    // A single-batch warp still carries a 1-bit pid so the port never collapses.
    function automatic int pid_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/alu_muldiv_lane_sequencer_if.sv
// Request (full warp) and batch (lane slice) handshake bundle.
// The sequencer uses the slave view; its upstream/downstream neighbours use master.
interface alu_muldiv_lane_sequencer_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 64
);
    localparam int PID_WIDTH = alu_muldiv_lane_sequencer_pkg::pid_width(
        alu_muldiv_lane_sequencer_pkg::num_batches(NUM_THREADS, NUM_LANES));

    logic                        in_valid;
    logic                        in_ready;
    logic [TAG_W-1:0]            in_tag;
    logic [NUM_THREADS-1:0]      in_tmask;
    logic [NUM_THREADS*XLEN-1:0] in_rs1;
    logic [NUM_THREADS*XLEN-1:0] in_rs2;

    logic                        out_valid;
    logic                        out_ready;
    logic [TAG_W-1:0]            out_tag;
    logic [NUM_LANES-1:0]        out_tmask;
    logic [NUM_LANES*XLEN-1:0]   out_rs1;
    logic [NUM_LANES*XLEN-1:0]   out_rs2;
    logic [PID_WIDTH-1:0]        out_pid;
    logic                        out_sop;
    logic                        out_eop;

    modport master (
        output in_valid, in_tag, in_tmask, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_tag, out_tmask, out_rs1, out_rs2,
               out_pid, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_tag, in_tmask, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_tag, out_tmask, out_rs1, out_rs2,
               out_pid, out_sop, out_eop
    );

endinterface

// File: rtl/alu_muldiv_lane_sequencer_lane_batch_finder.sv
// Combinational search over per-batch nonempty flags: lowest nonempty batch,
// and the lowest nonempty batch strictly above the current pid.
module lane_batch_finder #(
    parameter int NB    = 2,
    parameter int PID_W = 1
) (
    input  logic [NB-1:0]    nonempty,
    input  logic [PID_W-1:0] cur_pid,
    output logic [PID_W-1:0] next_pid,
    output logic             has_next,
    output logic [PID_W-1:0] first_pid
);

    // Kept in its own process: first_pid feeds back into cur_pid at the caller.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        first_pid = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (nonempty[b]) first_pid = PID_W'(b);
        end
    end

    always_comb begin
        next_pid = '0;
        has_next = 1'b0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (nonempty[b] && (b > int'(cur_pid))) begin
                next_pid = PID_W'(b);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_lane_sequencer.sv
// Splits one full-warp mul/div request into lane batches, tagging each with
// pid/sop/eop; optionally skips batches whose thread mask is all zero.
module alu_muldiv_lane_sequencer
    import alu_muldiv_lane_sequencer_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 64,
    parameter int SKIP_EMPTY  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    alu_muldiv_lane_sequencer_if.slave bus
);

    localparam int NB      = num_batches(NUM_THREADS, NUM_LANES);
    localparam int PID_W   = pid_width(NB);
    localparam int BATCH_W = NUM_LANES * XLEN;

    state_t                      state_q, state_d;
    logic [TAG_W-1:0]            tag_q;
    logic [NUM_THREADS-1:0]      tmask_q;
    logic [NUM_THREADS*XLEN-1:0] rs1_q;
    logic [NUM_THREADS*XLEN-1:0] rs2_q;
    logic [PID_W-1:0]            pid_q;
    logic                        sop_q;

    logic [NB-1:0]               nonempty;
    logic [PID_W-1:0]            cur_pid;
    logic [PID_W-1:0]            next_pid;
    logic [PID_W-1:0]            first_pid;
    logic [PID_W-1:0]            adv_pid;
    logic                        has_next;
    logic                        is_last;
    logic                        accept;
    logic                        fire;

    for (genvar b = 0; b < NB; b++) begin : g_nonempty
        assign nonempty[b] = |tmask_q[b*NUM_LANES +: NUM_LANES];
    end

    lane_batch_finder #(
        .NB    (NB),
        .PID_W (PID_W)
    ) u_finder (
        .nonempty  (nonempty),
        .cur_pid   (cur_pid),
        .next_pid  (next_pid),
        .has_next  (has_next),
        .first_pid (first_pid)
    );

    // On the first beat the batch is the lowest nonempty one of the freshly latched mask.
    always_comb begin
        cur_pid = pid_q;
        if ((SKIP_EMPTY != 0) && sop_q) cur_pid = first_pid;
    end

    always_comb begin
        if (SKIP_EMPTY != 0) begin
            is_last = !has_next;
            adv_pid = next_pid;
        end else begin
            is_last = (cur_pid == PID_W'(NB - 1));
            adv_pid = cur_pid + PID_W'(1);
        end
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign fire   = (state_q == ISSUE) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (fire && is_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pid_q <= '0;
            sop_q <= 1'b0;
        end else if (accept) begin
            pid_q <= '0;
            sop_q <= 1'b1;
        end else if (fire) begin
            sop_q <= 1'b0;
            if (!is_last) pid_q <= adv_pid;
        end
    end

    // NOTE: the operand/tag store has no reset; it is only read while in ISSUE.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q   <= bus.in_tag;
            tmask_q <= bus.in_tmask;
            rs1_q   <= bus.in_rs1;
            rs2_q   <= bus.in_rs2;
        end
    end

    always_comb begin
        bus.out_valid = (state_q == ISSUE);
        bus.in_ready  = reset && ((state_q == IDLE) || (is_last && bus.out_ready));
        bus.out_tag   = tag_q;
        bus.out_pid   = cur_pid;
        bus.out_sop   = sop_q;
        bus.out_eop   = (state_q == ISSUE) && is_last;
        bus.out_tmask = '0;
        bus.out_rs1   = '0;
        bus.out_rs2   = '0;
        for (int b = 0; b < NB; b++) begin
            if (cur_pid == PID_W'(b)) begin
                bus.out_tmask = tmask_q[b*NUM_LANES +: NUM_LANES];
                bus.out_rs1   = rs1_q[b*BATCH_W +: BATCH_W];
                bus.out_rs2   = rs2_q[b*BATCH_W +: BATCH_W];
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_lane_sequencer.sv
// Bench for the lane sequencer: directed scenarios with literal expectations
// plus randomized traffic checked against a beat-list reference model.
module tb_alu_muldiv_lane_sequencer;
    import alu_muldiv_lane_sequencer_pkg::*;

    localparam int NT = 4;
    localparam int NL = 2;
    localparam int XL = 32;
    localparam int TW = 64;
    localparam int NB = NT / NL;
    localparam int PW = pid_width(NB);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_muldiv_lane_sequencer_if #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .TAG_W(TW)) bus_a ();
    alu_muldiv_lane_sequencer_if #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .TAG_W(TW)) bus_b ();

    alu_muldiv_lane_sequencer #(
        .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .TAG_W(TW), .SKIP_EMPTY(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    alu_muldiv_lane_sequencer #(
        .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .TAG_W(TW), .SKIP_EMPTY(0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [PW-1:0]    pid;
        logic [NL-1:0]    tmask;
        logic [NL*XL-1:0] rs1;
        logic [NL*XL-1:0] rs2;
        logic [TW-1:0]    tag;
        logic             sop;
        logic             eop;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;
    bit    rand_rdy = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: list the batches that must be issued, in order, for one op.
    task automatic push_op(input logic [NT-1:0] m, input logic [NT*XL-1:0] a,
                           input logic [NT*XL-1:0] b, input logic [TW-1:0] tag);
        int    sel[$];
        beat_t bt;
        for (int k = 0; k < NB; k++)
            if (m[k*NL +: NL] != '0) sel.push_back(k);
        if (sel.size() == 0) sel.push_back(0);
        for (int k = 0; k < sel.size(); k++) begin
            bt.pid   = PW'(sel[k]);
            bt.tmask = m[sel[k]*NL +: NL];
            bt.rs1   = a[sel[k]*NL*XL +: NL*XL];
            bt.rs2   = b[sel[k]*NL*XL +: NL*XL];
            bt.tag   = tag;
            bt.sop   = (k == 0);
            bt.eop   = (k == sel.size() - 1);
            q.push_back(bt);
        end
    endtask

    // Compare process for the skipping instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_out_valid", bus_a.out_valid, q.size() != 0);
            check("mon_in_ready", bus_a.in_ready,
                  reset && (q.size() == 0 || (q.size() == 1 && bus_a.out_ready)));
            if (bus_a.out_valid && q.size() != 0) begin
                check("mon_pid",   bus_a.out_pid,   q[0].pid);
                check("mon_tmask", bus_a.out_tmask, q[0].tmask);
                check("mon_rs1",   bus_a.out_rs1,   q[0].rs1);
                check("mon_rs2",   bus_a.out_rs2,   q[0].rs2);
                check("mon_tag",   bus_a.out_tag,   q[0].tag);
                check("mon_sop",   bus_a.out_sop,   q[0].sop);
                check("mon_eop",   bus_a.out_eop,   q[0].eop);
                if (bus_a.out_ready && reset) void'(q.pop_front());
            end
            if (!reset) q.delete();
            else if (bus_a.in_valid && bus_a.in_ready)
                push_op(bus_a.in_tmask, bus_a.in_rs1, bus_a.in_rs2, bus_a.in_tag);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit to_b, input logic [NT-1:0] m, input logic [NT*XL-1:0] a,
                        input logic [NT*XL-1:0] b, input logic [TW-1:0] tag);
        bit acc = 1'b0;
        int n = 0;
        if (to_b) begin
            bus_b.in_valid = 1'b1; bus_b.in_tmask = m;
            bus_b.in_rs1 = a; bus_b.in_rs2 = b; bus_b.in_tag = tag;
        end else begin
            bus_a.in_valid = 1'b1; bus_a.in_tmask = m;
            bus_a.in_rs1 = a; bus_a.in_rs2 = b; bus_a.in_tag = tag;
        end
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = to_b ? bus_b.in_ready : bus_a.in_ready;
            cyc();
            n++;
        end
        check("send_accepted", acc, 1'b1);
        if (to_b) bus_b.in_valid = 1'b0;
        else      bus_a.in_valid = 1'b0;
    endtask

    initial forever begin
        cyc();
        if (rand_rdy) bus_a.out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [NT*XL-1:0] OPS_A = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [NT*XL-1:0] OPS_B = {32'd40, 32'd30, 32'd20, 32'd10};
    localparam logic [NT*XL-1:0] OPS_C = {32'd8, 32'd7, 32'd6, 32'd5};

    initial begin
        logic [NT-1:0]    m;
        logic [NT*XL-1:0] ra, rb;
        logic [TW-1:0]    tg;
        int               n;

        bus_a.in_valid = 1'b0; bus_a.in_tag = '0; bus_a.in_tmask = '0;
        bus_a.in_rs1 = '0; bus_a.in_rs2 = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_tag = '0; bus_b.in_tmask = '0;
        bus_b.in_rs1 = '0; bus_b.in_rs2 = '0; bus_b.out_ready = 1'b1;

        repeat (3) cyc();
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", bus_a.out_valid, 1'b0);
        check("rst_out_pid",   bus_a.out_pid,   '0);
        check("rst_out_sop",   bus_a.out_sop,   1'b0);
        check("rst_out_eop",   bus_a.out_eop,   1'b0);
        check("rst_in_ready",  bus_a.in_ready,  1'b0);
        cyc();
        reset = 1'b1;
        bus_a.out_ready = 1'b1;

        // Full mask, two beats.
        send(1'b0, 4'b1111, OPS_A, OPS_B, 64'hA1);
        @(negedge clk);
        check("t1_b0_pid", bus_a.out_pid, 1'b0);
        check("t1_b0_rs1", bus_a.out_rs1, 64'h00000002_00000001);
        check("t1_b0_rs2", bus_a.out_rs2, 64'h00000014_0000000A);
        check("t1_b0_tmask", bus_a.out_tmask, 2'b11);
        check("t1_b0_sopeop", {bus_a.out_sop, bus_a.out_eop}, 2'b10);
        cyc();
        @(negedge clk);
        check("t1_b1_pid", bus_a.out_pid, 1'b1);
        check("t1_b1_rs1", bus_a.out_rs1, 64'h00000004_00000003);
        check("t1_b1_sopeop", {bus_a.out_sop, bus_a.out_eop}, 2'b01);
        cyc();
        @(negedge clk);
        check("t1_idle_valid", bus_a.out_valid, 1'b0);
        cyc();

        // Upper half only: one beat when skipping, two beats otherwise.
        send(1'b0, 4'b1100, OPS_A, OPS_B, 64'hA2);
        @(negedge clk);
        check("t2_pid", bus_a.out_pid, 1'b1);
        check("t2_tmask", bus_a.out_tmask, 2'b11);
        check("t2_rs1", bus_a.out_rs1, 64'h00000004_00000003);
        check("t2_sopeop", {bus_a.out_sop, bus_a.out_eop}, 2'b11);
        cyc();
        @(negedge clk);
        check("t2_idle_valid", bus_a.out_valid, 1'b0);
        cyc();
        send(1'b1, 4'b1100, OPS_A, OPS_B, 64'hB2);
        @(negedge clk);
        check("t2n_b0_pid", bus_b.out_pid, 1'b0);
        check("t2n_b0_tmask", bus_b.out_tmask, 2'b00);
        check("t2n_b0_sopeop", {bus_b.out_sop, bus_b.out_eop}, 2'b10);
        cyc();
        @(negedge clk);
        check("t2n_b1_pid", bus_b.out_pid, 1'b1);
        check("t2n_b1_tmask", bus_b.out_tmask, 2'b11);
        check("t2n_b1_sopeop", {bus_b.out_sop, bus_b.out_eop}, 2'b01);
        cyc();
        @(negedge clk);
        check("t2n_idle_valid", bus_b.out_valid, 1'b0);
        cyc();

        // All-zero mask still commits one beat.
        send(1'b0, 4'b0000, OPS_A, OPS_B, 64'hA3);
        @(negedge clk);
        check("t3_pid", bus_a.out_pid, 1'b0);
        check("t3_tmask", bus_a.out_tmask, 2'b00);
        check("t3_sopeop", {bus_a.out_sop, bus_a.out_eop}, 2'b11);
        cyc();
        @(negedge clk);
        check("t3_idle_valid", bus_a.out_valid, 1'b0);
        check("t3_idle_ready", bus_a.in_ready, 1'b1);
        cyc();

        // Backpressure holds beat 0.
        bus_a.out_ready = 1'b0;
        send(1'b0, 4'b1111, OPS_A, OPS_B, 64'hA4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_hold_pid", bus_a.out_pid, 1'b0);
            check("t4_hold_rs1", bus_a.out_rs1, 64'h00000002_00000001);
            check("t4_hold_sop", bus_a.out_sop, 1'b1);
            check("t4_hold_in_ready", bus_a.in_ready, 1'b0);
            cyc();
        end
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        check("t4_rel_pid", bus_a.out_pid, 1'b0);
        cyc();
        @(negedge clk);
        check("t4_b1_pid", bus_a.out_pid, 1'b1);
        check("t4_b1_eop", bus_a.out_eop, 1'b1);
        cyc();
        cyc();

        // Back-to-back ops with no bubble.
        send(1'b0, 4'b1111, OPS_A, OPS_B, 64'hA5);
        bus_a.in_valid = 1'b1; bus_a.in_tmask = 4'b1111;
        bus_a.in_rs1 = OPS_C; bus_a.in_rs2 = OPS_B; bus_a.in_tag = 64'hA6;
        @(negedge clk);
        check("t5_b0", {bus_a.out_valid, bus_a.out_pid, bus_a.in_ready}, 3'b100);
        cyc();
        @(negedge clk);
        check("t5_b1", {bus_a.out_valid, bus_a.out_pid, bus_a.in_ready}, 3'b111);
        cyc();
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        check("t5_b2", {bus_a.out_valid, bus_a.out_pid, bus_a.out_sop}, 3'b101);
        check("t5_b2_rs1", bus_a.out_rs1, 64'h00000006_00000005);
        check("t5_b2_tag", bus_a.out_tag, 64'hA6);
        cyc();
        @(negedge clk);
        check("t5_b3", {bus_a.out_valid, bus_a.out_pid, bus_a.out_eop}, 3'b111);
        cyc();
        @(negedge clk);
        check("t5_idle_valid", bus_a.out_valid, 1'b0);
        cyc();

        // Reset mid-sequence discards the op.
        bus_a.out_ready = 1'b0;
        send(1'b0, 4'b1111, OPS_A, OPS_B, 64'hA7);
        @(negedge clk);
        check("t6_b0_valid", bus_a.out_valid, 1'b1);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_in_ready", bus_a.in_ready, 1'b0);
        cyc();
        @(negedge clk);
        check("t6_rst_valid", bus_a.out_valid, 1'b0);
        check("t6_rst_in_ready2", bus_a.in_ready, 1'b0);
        cyc();
        reset = 1'b1;
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        check("t6_rel_in_ready", bus_a.in_ready, 1'b1);
        check("t6_rel_valid", bus_a.out_valid, 1'b0);
        cyc();
        @(negedge clk);
        check("t6_no_stale", bus_a.out_valid, 1'b0);
        cyc();

        // Randomized traffic with random downstream backpressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 300; r++) begin
            repeat ($urandom_range(0, 2)) cyc();
            m  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            tg = {$urandom, $urandom};
            send(1'b0, m, ra, rb, tg);
        end
        rand_rdy = 1'b0;
        bus_a.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        check("drain_empty", q.size() == 0, 1'b1);
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
